// File: rtl/arb_pkg.sv
// Shared definitions for the 8-requester fixed-priority arbiter.
// Holds requester count, index width and the arbiter state encoding.
package arb_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRANT = 2'b01,
      GAP   = 2'b10
   } arb_state_t;

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder, bit 7 highest.
// any is high when at least one input bit is set.
module prio_enc8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      idx = '0;
      any = |vec;
      // ascending scan: the last set bit seen is the highest one
      for (int i = 0; i < N_REQ; i++) begin
         if (vec[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/prio_arbiter8.sv
// Sequential fixed-priority arbiter with bounded hold, forced release,
// one-shot masking of the preempted requester and a turnaround gap.
module prio_arbiter8
   import arb_pkg::*;
#(
   parameter int HOLD_MAX = 15
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             timeout
);

   localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

   arb_state_t       state, state_n;
   logic [7:0]       hold_cnt, hold_cnt_n;
   logic [N_REQ-1:0] mask, mask_n;
   logic [N_REQ-1:0] grant_n;
   logic [IDX_W-1:0] grant_idx_n;
   logic             timeout_n;

   logic [N_REQ-1:0] eligible;
   logic [N_REQ-1:0] arb_vec;
   logic [IDX_W-1:0] win_idx;
   logic             win_any;

   // masked requester still wins when it is the only one asking
   assign eligible = req & ~mask;
   assign arb_vec  = (eligible != '0) ? eligible : req;

   prio_enc8 u_enc (
      .vec (arb_vec),
      .idx (win_idx),
      .any (win_any)
   );

   always_comb begin
      state_n     = state;
      hold_cnt_n  = hold_cnt;
      mask_n      = mask;
      grant_n     = grant;
      grant_idx_n = grant_idx;
      timeout_n   = 1'b0;
      unique case (state)
         IDLE, GAP: begin
            grant_n = '0;
            state_n = IDLE;
            if (win_any) begin
               state_n          = GRANT;
               grant_n[win_idx] = 1'b1;
               grant_idx_n      = win_idx;
               hold_cnt_n       = 8'd1;
               mask_n           = '0;
            end
         end
         GRANT: begin
            if (!req[grant_idx]) begin
               state_n = GAP;
               grant_n = '0;
            end else if (hold_cnt == HOLD_LIM) begin
               state_n           = GAP;
               grant_n           = '0;
               mask_n[grant_idx] = 1'b1;
               timeout_n         = 1'b1;
            end else begin
               hold_cnt_n = hold_cnt + 8'd1;
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         mask        <= '0;
         grant       <= '0;
         grant_idx   <= '0;
         grant_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_n;
         hold_cnt    <= hold_cnt_n;
         mask        <= mask_n;
         grant       <= grant_n;
         grant_idx   <= grant_idx_n;
         grant_valid <= |grant_n;
         timeout     <= timeout_n;
      end
   end

endmodule

// File: tb/tb_prio_arbiter8.sv
// Scoreboard bench for prio_arbiter8: directed request vectors push
// hand-computed expected outputs, a monitor pops and compares per cycle.
module tb_prio_arbiter8;

   typedef struct {
      logic [7:0] grant;
      logic [2:0] idx;
      logic       tmo;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int   total = 0;
   int   bad   = 0;
   exp_t q[$];

   prio_arbiter8 #(.HOLD_MAX(15)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // drive req, let one edge sample it, then queue the expected outputs
   task automatic step(input logic [7:0] r, input logic [7:0] g,
                       input logic [2:0] i, input logic t);
      exp_t e;
      req = r;
      @(posedge clk);
      #1;
      e.grant = g;
      e.idx   = i;
      e.tmo   = t;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("grant", 32'(grant), 32'(e.grant));
         chk("grant_idx", 32'(grant_idx), 32'(e.idx));
         chk("grant_valid", 32'(grant_valid), 32'(e.grant != 8'h00));
         chk("timeout", 32'(timeout), 32'(e.tmo));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      req   = 8'h00;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_idx", 32'(grant_idx), 32'h0);
      chk("rst_valid", 32'(grant_valid), 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);
      rst_n = 1'b1;
      step(8'h00, 8'h00, 3'd0, 1'b0);

      // simple request, release, gap, idle
      repeat (3) step(8'h05, 8'h04, 3'd2, 1'b0);
      step(8'h00, 8'h00, 3'd2, 1'b0);
      step(8'h00, 8'h00, 3'd2, 1'b0);

      // bit 7 holds 4 cycles then hands over after one gap
      repeat (4) step(8'h81, 8'h80, 3'd7, 1'b0);
      step(8'h01, 8'h00, 3'd7, 1'b0);
      step(8'h01, 8'h01, 3'd0, 1'b0);
      step(8'h00, 8'h00, 3'd0, 1'b0);
      step(8'h00, 8'h00, 3'd0, 1'b0);

      // forced release of bit 7, masked, bit 1 served, then bit 7 again
      repeat (15) step(8'h82, 8'h80, 3'd7, 1'b0);
      step(8'h82, 8'h00, 3'd7, 1'b1);
      repeat (2) step(8'h82, 8'h02, 3'd1, 1'b0);
      step(8'h80, 8'h00, 3'd1, 1'b0);
      step(8'h80, 8'h80, 3'd7, 1'b0);
      step(8'h00, 8'h00, 3'd7, 1'b0);
      step(8'h00, 8'h00, 3'd7, 1'b0);

      // lone masked requester re-granted through fallback, twice
      repeat (15) step(8'h10, 8'h10, 3'd4, 1'b0);
      step(8'h10, 8'h00, 3'd4, 1'b1);
      repeat (15) step(8'h10, 8'h10, 3'd4, 1'b0);
      step(8'h10, 8'h00, 3'd4, 1'b1);
      step(8'h10, 8'h10, 3'd4, 1'b0);
      step(8'h00, 8'h00, 3'd4, 1'b0);
      step(8'h00, 8'h00, 3'd4, 1'b0);

      // holder drops on its 15th cycle, re-asserts in gap and wins unmasked
      repeat (15) step(8'h0C, 8'h08, 3'd3, 1'b0);
      step(8'h04, 8'h00, 3'd3, 1'b0);
      step(8'h0C, 8'h08, 3'd3, 1'b0);
      step(8'h00, 8'h00, 3'd3, 1'b0);
      step(8'h00, 8'h00, 3'd3, 1'b0);

      // asynchronous reset in the middle of a grant
      repeat (2) step(8'h20, 8'h20, 3'd5, 1'b0);
      #5;
      rst_n = 1'b0;
      #1;
      chk("async_grant", 32'(grant), 32'h0);
      chk("async_idx", 32'(grant_idx), 32'h0);
      chk("async_valid", 32'(grant_valid), 32'h0);
      chk("async_timeout", 32'(timeout), 32'h0);
      @(posedge clk);
      #3;
      chk("rst_hold_grant", 32'(grant), 32'h0);
      rst_n = 1'b1;
      step(8'h20, 8'h20, 3'd5, 1'b0);
      step(8'h00, 8'h00, 3'd5, 1'b0);
      step(8'h00, 8'h00, 3'd5, 1'b0);

      @(negedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
